// File: rtl/mmu_pkg.sv
// Shared constants for the C128 MMU (8722) configuration controller:
// register offsets, reset values, field positions and common-RAM sizing.
package mmu_pkg;

   localparam logic [7:0] CR_OFS   = 8'h00;
   localparam logic [7:0] PCRA_OFS = 8'h01;
   localparam logic [7:0] PCRB_OFS = 8'h02;
   localparam logic [7:0] PCRC_OFS = 8'h03;
   localparam logic [7:0] PCRD_OFS = 8'h04;
   localparam logic [7:0] MCR_OFS  = 8'h05;
   localparam logic [7:0] RCR_OFS  = 8'h06;
   localparam logic [7:0] P0L_OFS  = 8'h07;
   localparam logic [7:0] P0H_OFS  = 8'h08;
   localparam logic [7:0] P1L_OFS  = 8'h09;
   localparam logic [7:0] P1H_OFS  = 8'h0A;
   localparam logic [7:0] VER_OFS  = 8'h0B;

   localparam logic [7:0]  IO_PAGE  = 8'hD5;
   localparam logic [15:0] LCR_BASE = 16'hFF00;
   localparam logic [15:0] LCR_LAST = 16'hFF04;

   localparam logic [7:0] CR_RST  = 8'h00;
   localparam logic [7:0] PCR_RST = 8'h00;
   localparam logic [7:0] MCR_RST = 8'h00;
   localparam logic [7:0] RCR_RST = 8'h00;
   localparam logic [7:0] P0L_RST = 8'h00;
   localparam logic [7:0] P0H_RST = 8'h00;
   localparam logic [7:0] P1L_RST = 8'h01;
   localparam logic [7:0] P1H_RST = 8'h00;

   localparam int CR_IO_BIT     = 0;
   localparam int CR_MS0_BIT    = 4;
   localparam int CR_MS1_BIT    = 5;
   localparam int CR_BANK_LSB   = 6;
   localparam int MCR_Z80_BIT   = 0;
   localparam int MCR_FSDIR_BIT = 3;
   localparam int MCR_C64_BIT   = 6;
   localparam int RCR_SIZE_LSB  = 0;
   localparam int RCR_BOT_BIT   = 2;
   localparam int RCR_TOP_BIT   = 3;
   localparam int RCR_VIC_LSB   = 6;

   localparam logic [15:0] COMMON_MASK_1K  = 16'h03FF;
   localparam logic [15:0] COMMON_MASK_4K  = 16'h0FFF;
   localparam logic [15:0] COMMON_MASK_8K  = 16'h1FFF;
   localparam logic [15:0] COMMON_MASK_16K = 16'h3FFF;

   function automatic logic [15:0] common_mask(input logic [1:0] size_sel);
      logic [15:0] mask;
      case (size_sel)
         2'd0:    mask = COMMON_MASK_1K;
         2'd1:    mask = COMMON_MASK_4K;
         2'd2:    mask = COMMON_MASK_8K;
         2'd3:    mask = COMMON_MASK_16K;
         default: mask = COMMON_MASK_1K;
      endcase
      return mask;
   endfunction

   // Unimplemented banks alias onto the populated ones.
   function automatic logic [1:0] bank_wrap(input logic [1:0] bank, input int unsigned banks);
      return 2'({30'd0, bank} % banks);
   endfunction

endpackage

// File: rtl/mmu_page_xlate.sv
// Combinational page-0/page-1 relocation and common-RAM bank override
// applied to every CPU access; the VIC sees its own bank untranslated.
module mmu_page_xlate
   import mmu_pkg::*;
(
   input  logic        aec_i,
   input  logic [15:0] addr_i,
   input  logic [7:0]  p0l_i,
   input  logic [7:0]  p1l_i,
   input  logic [1:0]  common_size_i,
   input  logic        share_bot_i,
   input  logic        share_top_i,
   input  logic [1:0]  cpu_bank_i,
   input  logic [1:0]  vic_bank_i,
   output logic [7:0]  ta_o,
   output logic [1:0]  ram_bank_o
);

   logic [7:0]  page_s;
   logic [15:0] mask_s;
   logic        in_common_s;

   assign page_s = addr_i[15:8];
   assign mask_s = common_mask(common_size_i);

   // Page swap: zero page and stack trade places with their pointer pages, earlier rule wins.
   always_comb begin
      ta_o = page_s;
      if (!aec_i) begin
         ta_o = page_s;
      end else if (page_s == 8'h00) begin
         ta_o = p0l_i;
      end else if (page_s == p0l_i) begin
         ta_o = 8'h00;
      end else if (page_s == 8'h01) begin
         ta_o = p1l_i;
      end else if (page_s == p1l_i) begin
         ta_o = 8'h01;
      end else begin
         ta_o = page_s;
      end
   end

   assign in_common_s = (share_bot_i && ((addr_i & ~mask_s) == 16'h0000)) ||
                        (share_top_i && ((addr_i | mask_s) == 16'hFFFF));

   // Bank select: VIC cycles use the VIC bank, shared regions always hit bank 0.
   always_comb begin
      ram_bank_o = cpu_bank_i;
      if (!aec_i) begin
         ram_bank_o = vic_bank_i;
      end else if (in_common_s) begin
         ram_bank_o = 2'd0;
      end else begin
         ram_bank_o = cpu_bank_i;
      end
   end

endmodule

// File: rtl/mmu_cfg_ctrl.sv
// C128 MMU register file and CPU bus decode; drives the PLA memory-select
// lines and the translated address/bank for the DRAM array.
module mmu_cfg_ctrl
   import mmu_pkg::*;
#(
   parameter logic [7:0]  VERSION   = 8'h20,
   parameter int unsigned RAM_BANKS = 2
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] addr_i,
   input  logic [7:0]  din_i,
   input  logic        rw_i,
   input  logic        aec_i,
   input  logic        cpu_cyc_i,
   output logic [7:0]  dout_o,
   output logic        dout_en_o,
   output logic        ms0_o,
   output logic        ms1_o,
   output logic        ms2_o,
   output logic        ms3_o,
   output logic        z80en_o,
   output logic        fsdir_o,
   output logic [7:0]  ta_o,
   output logic [1:0]  ram_bank_o,
   output logic [1:0]  vic_bank_o
);

   logic [7:0]       cr_q, cr_d, mcr_q, mcr_d, rcr_q, rcr_d;
   logic [3:0][7:0]  pcr_q, pcr_d;
   logic [7:0]       p0l_q, p0l_d, p0h_q, p0h_d, p1l_q, p1l_d, p1h_q, p1h_d;
   logic [7:0]       p0h_stage_q, p0h_stage_d, p1h_stage_q, p1h_stage_d;

   logic       c128_s, ff_hit_s, io_hit_s, hit_s, wr_s;
   logic [7:0] ofs_s, rd_data_s;
   logic [1:0] cpu_bank_s, vic_bank_s;
   logic       unused_s;

   assign c128_s   = !mcr_q[MCR_C64_BIT];
   assign ff_hit_s = c128_s && (addr_i >= LCR_BASE) && (addr_i <= LCR_LAST);
   assign io_hit_s = c128_s && !cr_q[CR_IO_BIT] && (addr_i[15:8] == IO_PAGE);
   assign hit_s    = ff_hit_s || io_hit_s;
   assign wr_s     = cpu_cyc_i && aec_i && !rw_i;
   assign ofs_s    = addr_i[7:0];

   // Register next-state; only a committed CPU write changes anything.
   always_comb begin
      cr_d        = cr_q;
      pcr_d       = pcr_q;
      mcr_d       = mcr_q;
      rcr_d       = rcr_q;
      p0l_d       = p0l_q;
      p0h_d       = p0h_q;
      p1l_d       = p1l_q;
      p1h_d       = p1h_q;
      p0h_stage_d = p0h_stage_q;
      p1h_stage_d = p1h_stage_q;
      if (wr_s && ff_hit_s) begin
         case (addr_i[2:0])
            3'd0:    cr_d = din_i;
            3'd1:    cr_d = pcr_q[0];
            3'd2:    cr_d = pcr_q[1];
            3'd3:    cr_d = pcr_q[2];
            3'd4:    cr_d = pcr_q[3];
            default: cr_d = cr_q;
         endcase
      end else if (wr_s && io_hit_s) begin
         // High pointer bytes are staged and only take effect with the low-byte write.
         case (ofs_s)
            CR_OFS:   cr_d     = din_i;
            PCRA_OFS: pcr_d[0] = din_i;
            PCRB_OFS: pcr_d[1] = din_i;
            PCRC_OFS: pcr_d[2] = din_i;
            PCRD_OFS: pcr_d[3] = din_i;
            MCR_OFS:  mcr_d    = din_i;
            RCR_OFS:  rcr_d    = din_i;
            P0L_OFS: begin
               p0l_d = din_i;
               p0h_d = p0h_stage_q;
            end
            P0H_OFS:  p0h_stage_d = din_i;
            P1L_OFS: begin
               p1l_d = din_i;
               p1h_d = p1h_stage_q;
            end
            P1H_OFS:  p1h_stage_d = din_i;
            default:  cr_d = cr_q;
         endcase
      end else begin
         cr_d = cr_q;
      end
   end

   // Register file state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cr_q        <= CR_RST;
         pcr_q       <= {4{PCR_RST}};
         mcr_q       <= MCR_RST;
         rcr_q       <= RCR_RST;
         p0l_q       <= P0L_RST;
         p0h_q       <= P0H_RST;
         p1l_q       <= P1L_RST;
         p1h_q       <= P1H_RST;
         p0h_stage_q <= P0H_RST;
         p1h_stage_q <= P1H_RST;
      end else begin
         cr_q        <= cr_d;
         pcr_q       <= pcr_d;
         mcr_q       <= mcr_d;
         rcr_q       <= rcr_d;
         p0l_q       <= p0l_d;
         p0h_q       <= p0h_d;
         p1l_q       <= p1l_d;
         p1h_q       <= p1h_d;
         p0h_stage_q <= p0h_stage_d;
         p1h_stage_q <= p1h_stage_d;
      end
   end

   // Read mux; unimplemented MCR/RCR bits and unused $D5xx slots read as ones.
   always_comb begin
      rd_data_s = 8'h00;
      if (ff_hit_s) begin
         case (addr_i[2:0])
            3'd0:    rd_data_s = cr_q;
            3'd1:    rd_data_s = pcr_q[0];
            3'd2:    rd_data_s = pcr_q[1];
            3'd3:    rd_data_s = pcr_q[2];
            3'd4:    rd_data_s = pcr_q[3];
            default: rd_data_s = 8'hFF;
         endcase
      end else if (io_hit_s) begin
         case (ofs_s)
            CR_OFS:   rd_data_s = cr_q;
            PCRA_OFS: rd_data_s = pcr_q[0];
            PCRB_OFS: rd_data_s = pcr_q[1];
            PCRC_OFS: rd_data_s = pcr_q[2];
            PCRD_OFS: rd_data_s = pcr_q[3];
            MCR_OFS:  rd_data_s = {mcr_q[7:6], 2'b11, mcr_q[3:0]};
            RCR_OFS:  rd_data_s = {rcr_q[7:6], 2'b11, rcr_q[3:0]};
            P0L_OFS:  rd_data_s = p0l_q;
            P0H_OFS:  rd_data_s = p0h_stage_q;
            P1L_OFS:  rd_data_s = p1l_q;
            P1H_OFS:  rd_data_s = p1h_stage_q;
            VER_OFS:  rd_data_s = VERSION;
            default:  rd_data_s = 8'hFF;
         endcase
      end else begin
         rd_data_s = 8'h00;
      end
   end

   assign dout_o    = rd_data_s;
   assign dout_en_o = aec_i && rw_i && hit_s && cpu_cyc_i;

   assign ms2_o   = cr_q[CR_IO_BIT];
   assign ms0_o   = cr_q[CR_MS0_BIT];
   assign ms1_o   = cr_q[CR_MS1_BIT];
   assign ms3_o   = !mcr_q[MCR_C64_BIT];
   assign z80en_o = !mcr_q[MCR_Z80_BIT];
   assign fsdir_o = mcr_q[MCR_FSDIR_BIT];

   assign cpu_bank_s = bank_wrap(cr_q[CR_BANK_LSB +: 2], RAM_BANKS);
   assign vic_bank_s = bank_wrap(rcr_q[RCR_VIC_LSB +: 2], RAM_BANKS);
   assign vic_bank_o = vic_bank_s;

   // Committed pointer high bytes and the read-as-one bits have no consumer in this model.
   assign unused_s = ^{p0h_q, p1h_q, mcr_q[5:4], rcr_q[5:4]};

   mmu_page_xlate u_xlate (
      .aec_i         (aec_i),
      .addr_i        (addr_i),
      .p0l_i         (p0l_q),
      .p1l_i         (p1l_q),
      .common_size_i (rcr_q[RCR_SIZE_LSB +: 2]),
      .share_bot_i   (rcr_q[RCR_BOT_BIT]),
      .share_top_i   (rcr_q[RCR_TOP_BIT]),
      .cpu_bank_i    (cpu_bank_s),
      .vic_bank_i    (vic_bank_s),
      .ta_o          (ta_o),
      .ram_bank_o    (ram_bank_o)
   );

endmodule

// File: tb/tb_mmu_cfg_ctrl.sv
// Directed plus randomized bench for mmu_cfg_ctrl, checked against a
// behavioural register/translation model of the 8722 MMU.
module tb_mmu_cfg_ctrl;

   localparam logic [7:0] VERSION   = 8'h20;
   localparam int         RAM_BANKS = 2;

   logic        clk = 1'b0;
   logic        clk_en = 1'b1;
   logic        rst = 1'b1;
   logic [15:0] addr = 16'h1234;
   logic [7:0]  din = 8'h00;
   logic        rw = 1'b1;
   logic        aec = 1'b1;
   logic        cpu_cyc = 1'b0;
   logic [7:0]  dout, ta;
   logic        dout_en, ms0, ms1, ms2, ms3, z80en, fsdir;
   logic [1:0]  ram_bank, vic_bank;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] s_dout, s_ta;
   logic       s_en;
   logic [1:0] s_bank;

   // Reference model state
   logic [7:0] m_cr, m_mcr, m_rcr, m_st0, m_st1;
   logic [7:0] m_pcr [4];
   int         m_p0, m_p1;

   always #5 if (clk_en) clk = ~clk;

   mmu_cfg_ctrl #(.VERSION(VERSION), .RAM_BANKS(RAM_BANKS)) dut (
      .clk_i(clk), .rst_i(rst), .addr_i(addr), .din_i(din), .rw_i(rw),
      .aec_i(aec), .cpu_cyc_i(cpu_cyc), .dout_o(dout), .dout_en_o(dout_en),
      .ms0_o(ms0), .ms1_o(ms1), .ms2_o(ms2), .ms3_o(ms3), .z80en_o(z80en),
      .fsdir_o(fsdir), .ta_o(ta), .ram_bank_o(ram_bank), .vic_bank_o(vic_bank)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_cr = 8'h00; m_mcr = 8'h00; m_rcr = 8'h00; m_st0 = 8'h00; m_st1 = 8'h00;
      for (int i = 0; i < 4; i++) m_pcr[i] = 8'h00;
      m_p0 = 0;
      m_p1 = 1;
   endfunction

   function automatic logic model_ff(input logic [15:0] a);
      return (m_mcr[6] == 1'b0) && (int'(a) >= 'hFF00) && (int'(a) <= 'hFF04);
   endfunction

   function automatic logic model_io(input logic [15:0] a);
      return (m_mcr[6] == 1'b0) && (m_cr[0] == 1'b0) && (int'(a) >= 'hD500) && (int'(a) <= 'hD5FF);
   endfunction

   function automatic logic [7:0] model_rdata(input logic [15:0] a);
      int off;
      if (model_ff(a)) begin
         off = int'(a) - 'hFF00;
         return (off == 0) ? m_cr : m_pcr[off - 1];
      end
      off = int'(a) - 'hD500;
      case (off)
         0:       return m_cr;
         1, 2, 3, 4: return m_pcr[off - 1];
         5:       return m_mcr | 8'h30;
         6:       return m_rcr | 8'h30;
         7:       return 8'(m_p0 % 256);
         8:       return m_st0;
         9:       return 8'(m_p1 % 256);
         10:      return m_st1;
         11:      return VERSION;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
      int off;
      if (model_ff(a)) begin
         off = int'(a) - 'hFF00;
         m_cr = (off == 0) ? d : m_pcr[off - 1];
      end else if (model_io(a)) begin
         off = int'(a) - 'hD500;
         case (off)
            0:          m_cr = d;
            1, 2, 3, 4: m_pcr[off - 1] = d;
            5:          m_mcr = d;
            6:          m_rcr = d;
            7:          m_p0 = int'(m_st0) * 256 + int'(d);
            8:          m_st0 = d;
            9:          m_p1 = int'(m_st1) * 256 + int'(d);
            10:         m_st1 = d;
            default:    m_cr = m_cr;
         endcase
      end
   endfunction

   function automatic int model_ta(input logic [15:0] a, input logic ae);
      int pg, z, s;
      pg = int'(a) / 256;
      z  = m_p0 % 256;
      s  = m_p1 % 256;
      if (!ae)          return pg;
      if (pg == 0)      return z;
      if (pg == z)      return 0;
      if (pg == 1)      return s;
      if (pg == s)      return 1;
      return pg;
   endfunction

   function automatic int model_bank(input logic [15:0] a, input logic ae);
      int sz;
      if (!ae) return (int'(m_rcr) / 64) % RAM_BANKS;
      case (int'(m_rcr) % 4)
         0:       sz = 1024;
         1:       sz = 4096;
         2:       sz = 8192;
         default: sz = 16384;
      endcase
      if (m_rcr[2] && int'(a) < sz)          return 0;
      if (m_rcr[3] && int'(a) >= 65536 - sz) return 0;
      return (int'(m_cr) / 64) % RAM_BANKS;
   endfunction

   task automatic check_static();
      chk("ms0", 16'(ms0), 16'(m_cr[4]));
      chk("ms1", 16'(ms1), 16'(m_cr[5]));
      chk("ms2", 16'(ms2), 16'(m_cr[0]));
      chk("ms3", 16'(ms3), 16'(!m_mcr[6]));
      chk("z80en", 16'(z80en), 16'(!m_mcr[0]));
      chk("fsdir", 16'(fsdir), 16'(m_mcr[3]));
      chk("vic_bank", 16'(vic_bank), 16'((int'(m_rcr) / 64) % RAM_BANKS));
   endtask

   task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic r, input logic ae);
      logic exp_hit;
      @(negedge clk);
      addr = a; din = d; rw = r; aec = ae; cpu_cyc = 1'b1;
      #1;
      exp_hit = model_ff(a) || model_io(a);
      s_dout = dout; s_en = dout_en; s_ta = ta; s_bank = ram_bank;
      chk("dout_en", 16'(dout_en), 16'(ae && r && exp_hit));
      if (ae && r && exp_hit) chk("dout", 16'(dout), 16'(model_rdata(a)));
      chk("ta", 16'(ta), 16'(model_ta(a, ae)));
      chk("ram_bank", 16'(ram_bank), 16'(model_bank(a, ae)));
      check_static();
      @(posedge clk);
      if (ae && !r && exp_hit) model_write(a, d);
      #1;
      cpu_cyc = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clk_en = 1'b0;
      cpu_cyc = 1'b0;
      #2 rst = 1'b1;
      #10 rst = 1'b0;
      model_reset();
      #2;
      chk("rst_ms0", 16'(ms0), 16'h0000);
      chk("rst_ms1", 16'(ms1), 16'h0000);
      chk("rst_ms2", 16'(ms2), 16'h0000);
      chk("rst_ms3", 16'(ms3), 16'h0001);
      chk("rst_z80en", 16'(z80en), 16'h0001);
      chk("rst_fsdir", 16'(fsdir), 16'h0000);
      chk("rst_ram_bank", 16'(ram_bank), 16'h0000);
      chk("rst_vic_bank", 16'(vic_bank), 16'h0000);
      chk("rst_dout_en", 16'(dout_en), 16'h0000);
      chk("rst_ta", 16'(ta), 16'(addr[15:8]));
      clk_en = 1'b1;
   endtask

   logic [15:0] ra;
   logic [7:0]  rd;
   logic        rr, rae;
   int          cls;

   initial begin
      model_reset();
      #3;
      do_reset();

      // Power-on register contents
      bus_cycle(16'hD509, 8'h00, 1'b1, 1'b1);
      chk("p1l_reset", 16'(s_dout), 16'h0001);
      bus_cycle(16'hD50B, 8'h00, 1'b1, 1'b1);
      chk("version", 16'(s_dout), 16'(VERSION));

      // LCR through $FF02 from PCR B
      bus_cycle(16'hD502, 8'h7F, 1'b0, 1'b1);
      bus_cycle(16'hFF02, 8'h00, 1'b0, 1'b1);
      chk("lcr_ms2", 16'(ms2), 16'h0001);
      chk("lcr_ms0", 16'(ms0), 16'h0001);
      chk("lcr_ms1", 16'(ms1), 16'h0001);
      bus_cycle(16'h8000, 8'h00, 1'b1, 1'b1);
      chk("lcr_bank", 16'(s_bank), 16'h0001);
      bus_cycle(16'hD500, 8'h00, 1'b1, 1'b1);
      chk("io_off_en", 16'(s_en), 16'h0000);
      bus_cycle(16'hFF00, 8'h40, 1'b0, 1'b1);

      // Zero-page relocation with staged high byte
      bus_cycle(16'hD508, 8'h00, 1'b0, 1'b1);
      bus_cycle(16'h0012, 8'h00, 1'b1, 1'b1);
      chk("p0_staged_ta", 16'(s_ta), 16'h0000);
      bus_cycle(16'hD507, 8'h40, 1'b0, 1'b1);
      bus_cycle(16'h0012, 8'h00, 1'b1, 1'b1);
      chk("p0_swap_ta", 16'(s_ta), 16'h0040);
      bus_cycle(16'h4012, 8'h00, 1'b1, 1'b1);
      chk("p0_back_ta", 16'(s_ta), 16'h0000);

      // 16K bottom common RAM
      bus_cycle(16'hD506, 8'h07, 1'b0, 1'b1);
      bus_cycle(16'h3FFF, 8'h00, 1'b1, 1'b1);
      chk("common_in", 16'(s_bank), 16'h0000);
      bus_cycle(16'h4000, 8'h00, 1'b1, 1'b1);
      chk("common_out", 16'(s_bank), 16'h0001);

      // C64 mode hides every register
      bus_cycle(16'hD505, 8'h41, 1'b0, 1'b1);
      chk("c64_ms3", 16'(ms3), 16'h0000);
      chk("c64_z80en", 16'(z80en), 16'h0000);
      bus_cycle(16'hFF00, 8'hAA, 1'b0, 1'b1);
      bus_cycle(16'h8000, 8'h00, 1'b1, 1'b1);
      chk("c64_cr_kept", 16'(s_bank), 16'h0001);
      bus_cycle(16'hD505, 8'h00, 1'b1, 1'b1);
      chk("c64_mcr_en", 16'(s_en), 16'h0000);

      // Reset during a $FF00 write aborts the commit
      do_reset();
      @(negedge clk);
      addr = 16'hFF00; din = 8'hFF; rw = 1'b0; aec = 1'b1; cpu_cyc = 1'b1;
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      cpu_cyc = 1'b0;
      model_reset();
      bus_cycle(16'hFF00, 8'h00, 1'b1, 1'b1);
      chk("rst_abort_cr", 16'(s_dout), 16'h0000);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cls = int'($urandom_range(0, 4));
         case (cls)
            0:       ra = 16'hFF00 + 16'($urandom_range(0, 4));
            1, 2:    ra = 16'hD500 + 16'($urandom_range(0, 15));
            3:       ra = {8'($urandom_range(0, 2)), 8'($urandom)};
            default: ra = 16'($urandom);
         endcase
         rd  = 8'($urandom);
         rr  = 1'($urandom);
         rae = ($urandom_range(0, 7) != 0);
         if (ra == 16'hD505 && $urandom_range(0, 7) != 0) rd[6] = 1'b0;
         if (i % 100 == 99) do_reset();
         bus_cycle(ra, rd, rr, rae);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
